// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite constants and types for the register front end and its slice.
package axi4l_pkg;

    localparam logic [1:0] AXI4L_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4L_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4L_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_BUSY,
        SKID_FULL
    } axi4l_skid_state_t;

endpackage

// File: rtl/axi4l_skid_buf.sv
// Two-entry skid buffer: registered valid/ready, one beat per cycle, 1-cycle latency.
module axi4l_skid_buf
    import axi4l_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    axi4l_skid_state_t state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q;
    logic             load_main, load_skid;
    logic             push, pop;

    // Handshakes use the flopped flags so in_ready stays 0 until the first edge out of reset.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SKID_EMPTY: if (push) state_d = SKID_BUSY;
            SKID_BUSY: begin
                if (push && !pop)      state_d = SKID_FULL;
                else if (!push && pop) state_d = SKID_EMPTY;
            end
            SKID_FULL:  if (pop) state_d = SKID_BUSY;
            default:    state_d = SKID_EMPTY;
        endcase
    end

    always_comb begin
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
        load_main   = (push && (state_q == SKID_EMPTY || (state_q == SKID_BUSY && pop)))
                   || (state_q == SKID_FULL && pop);
        load_skid   = push && (state_q == SKID_BUSY) && !pop;
        main_d      = (state_q == SKID_FULL) ? skid_q : in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_d;
            if (load_skid) skid_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/axi4l_slice.sv
// AXI4-Lite register slice: one optional skid buffer per channel, beats pass unchanged.
module axi4l_slice
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit AW_REG     = 1'b1,
    parameter bit W_REG      = 1'b1,
    parameter bit B_REG      = 1'b1,
    parameter bit AR_REG     = 1'b1,
    parameter bit R_REG      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int AW_W = ADDR_WIDTH + 3;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8;
    localparam int R_W  = DATA_WIDTH + 2;

    if (AW_REG) begin : g_aw
        axi4l_skid_buf #(.WIDTH(AW_W)) u_aw (
            .clk(clk), .rstn(rstn),
            .in_data({s_axi_awprot, s_axi_awaddr}), .in_valid(s_axi_awvalid), .in_ready(s_axi_awready),
            .out_data({m_axi_awprot, m_axi_awaddr}), .out_valid(m_axi_awvalid), .out_ready(m_axi_awready)
        );
    end else begin : g_aw_wire
        assign {m_axi_awprot, m_axi_awaddr} = {s_axi_awprot, s_axi_awaddr};
        assign m_axi_awvalid = s_axi_awvalid;
        assign s_axi_awready = m_axi_awready;
    end

    if (W_REG) begin : g_w
        axi4l_skid_buf #(.WIDTH(W_W)) u_w (
            .clk(clk), .rstn(rstn),
            .in_data({s_axi_wstrb, s_axi_wdata}), .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
            .out_data({m_axi_wstrb, m_axi_wdata}), .out_valid(m_axi_wvalid), .out_ready(m_axi_wready)
        );
    end else begin : g_w_wire
        assign {m_axi_wstrb, m_axi_wdata} = {s_axi_wstrb, s_axi_wdata};
        assign m_axi_wvalid = s_axi_wvalid;
        assign s_axi_wready = m_axi_wready;
    end

    if (B_REG) begin : g_b
        axi4l_skid_buf #(.WIDTH(2)) u_b (
            .clk(clk), .rstn(rstn),
            .in_data(m_axi_bresp), .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
            .out_data(s_axi_bresp), .out_valid(s_axi_bvalid), .out_ready(s_axi_bready)
        );
    end else begin : g_b_wire
        assign s_axi_bresp  = m_axi_bresp;
        assign s_axi_bvalid = m_axi_bvalid;
        assign m_axi_bready = s_axi_bready;
    end

    if (AR_REG) begin : g_ar
        axi4l_skid_buf #(.WIDTH(AW_W)) u_ar (
            .clk(clk), .rstn(rstn),
            .in_data({s_axi_arprot, s_axi_araddr}), .in_valid(s_axi_arvalid), .in_ready(s_axi_arready),
            .out_data({m_axi_arprot, m_axi_araddr}), .out_valid(m_axi_arvalid), .out_ready(m_axi_arready)
        );
    end else begin : g_ar_wire
        assign {m_axi_arprot, m_axi_araddr} = {s_axi_arprot, s_axi_araddr};
        assign m_axi_arvalid = s_axi_arvalid;
        assign s_axi_arready = m_axi_arready;
    end

    if (R_REG) begin : g_r
        axi4l_skid_buf #(.WIDTH(R_W)) u_r (
            .clk(clk), .rstn(rstn),
            .in_data({m_axi_rresp, m_axi_rdata}), .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
            .out_data({s_axi_rresp, s_axi_rdata}), .out_valid(s_axi_rvalid), .out_ready(s_axi_rready)
        );
    end else begin : g_r_wire
        assign {s_axi_rresp, s_axi_rdata} = {m_axi_rresp, m_axi_rdata};
        assign s_axi_rvalid = m_axi_rvalid;
        assign m_axi_rready = s_axi_rready;
    end

endmodule

// File: tb/tb_axi4l_slice.sv
// Channel-level bench for axi4l_slice: each channel is modelled as a 2-deep FIFO.
module tb_axi4l_slice;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
    logic [3:0]  s_axi_wstrb, m_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp, m_axi_bresp, m_axi_rresp;
    logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
    logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

    // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R (upstream side -> downstream side)
    logic        in_vld [5];
    logic [63:0] in_dat [5];
    logic        out_rdy[5];
    logic        in_rdy [5];
    logic        out_vld[5];
    logic [63:0] out_dat[5];

    assign {s_axi_awprot, s_axi_awaddr} = in_dat[0][34:0];
    assign {s_axi_wstrb, s_axi_wdata}   = in_dat[1][35:0];
    assign m_axi_bresp                  = in_dat[2][1:0];
    assign {s_axi_arprot, s_axi_araddr} = in_dat[3][34:0];
    assign {m_axi_rresp, m_axi_rdata}   = in_dat[4][33:0];
    assign s_axi_awvalid = in_vld[0];
    assign s_axi_wvalid  = in_vld[1];
    assign m_axi_bvalid  = in_vld[2];
    assign s_axi_arvalid = in_vld[3];
    assign m_axi_rvalid  = in_vld[4];
    assign m_axi_awready = out_rdy[0];
    assign m_axi_wready  = out_rdy[1];
    assign s_axi_bready  = out_rdy[2];
    assign m_axi_arready = out_rdy[3];
    assign s_axi_rready  = out_rdy[4];

    assign in_rdy[0] = s_axi_awready;
    assign in_rdy[1] = s_axi_wready;
    assign in_rdy[2] = m_axi_bready;
    assign in_rdy[3] = s_axi_arready;
    assign in_rdy[4] = m_axi_rready;
    assign out_vld[0] = m_axi_awvalid;
    assign out_vld[1] = m_axi_wvalid;
    assign out_vld[2] = s_axi_bvalid;
    assign out_vld[3] = m_axi_arvalid;
    assign out_vld[4] = s_axi_rvalid;
    assign out_dat[0] = {29'd0, m_axi_awprot, m_axi_awaddr};
    assign out_dat[1] = {28'd0, m_axi_wstrb, m_axi_wdata};
    assign out_dat[2] = {62'd0, s_axi_bresp};
    assign out_dat[3] = {29'd0, m_axi_arprot, m_axi_araddr};
    assign out_dat[4] = {30'd0, s_axi_rresp, s_axi_rdata};

    axi4l_slice dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] chan_mask(input int c);
        int w;
        case (c)
            0, 3:    w = 35;
            1:       w = 36;
            2:       w = 2;
            default: w = 34;
        endcase
        return (64'd1 << w) - 64'd1;
    endfunction

    // Model: each channel is a FIFO of depth 2; ready = not full, valid = not empty,
    // output payload = oldest entry. ready_en reflects the one-edge wake-up after reset.
    int          occ [5];
    logic [63:0] mbuf[5][2];
    bit          ready_en = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            ready_en = 1'b0;
            for (int c = 0; c < 5; c++) begin
                occ[c] = 0;
                chk($sformatf("rst_valid[%0d]", c), 64'(out_vld[c]), 64'd0);
                chk($sformatf("rst_ready[%0d]", c), 64'(in_rdy[c]), 64'd0);
                chk($sformatf("rst_payload[%0d]", c), out_dat[c], 64'd0);
            end
        end else begin
            for (int c = 0; c < 5; c++) begin
                bit ain, aout;
                chk($sformatf("ready[%0d]", c), 64'(in_rdy[c]), 64'(ready_en && occ[c] < 2));
                chk($sformatf("valid[%0d]", c), 64'(out_vld[c]), 64'(occ[c] > 0));
                if (occ[c] > 0) chk($sformatf("payload[%0d]", c), out_dat[c], mbuf[c][0]);
                ain  = in_vld[c] && ready_en && occ[c] < 2;
                aout = occ[c] > 0 && out_rdy[c];
                if (aout) begin
                    mbuf[c][0] = mbuf[c][1];
                    occ[c]--;
                end
                if (ain) begin
                    mbuf[c][occ[c]] = in_dat[c];
                    occ[c]++;
                end
            end
            ready_en = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int c = 0; c < 5; c++) in_vld[c] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            in_vld[c] = 1'b0; in_dat[c] = '0; out_rdy[c] = 1'b0;
        end
        rstn = 1'b0;
        repeat (10) tick();
        rstn = 1'b1;
        tick();
        chk("awready_after_rst", 64'(s_axi_awready), 64'd1);
        chk("wready_after_rst",  64'(s_axi_wready),  64'd1);
        chk("arready_after_rst", 64'(s_axi_arready), 64'd1);
        chk("bready_after_rst",  64'(m_axi_bready),  64'd1);
        chk("rready_after_rst",  64'(m_axi_rready),  64'd1);

        // Single write and readback of 0x80000000
        for (int c = 0; c < 5; c++) out_rdy[c] = 1'b1;
        in_vld[0] = 1'b1; in_dat[0] = {29'd0, 3'd0, 32'h8000_0000};
        in_vld[1] = 1'b1; in_dat[1] = {28'd0, 4'hF, 32'hDEAD_BEEF};
        chk("awvalid_before_accept", 64'(m_axi_awvalid), 64'd0);
        tick();
        idle_all();
        chk("awvalid_latency", 64'(m_axi_awvalid), 64'd1);
        chk("awaddr_single", 64'(m_axi_awaddr), 64'h8000_0000);
        chk("wdata_single", 64'(m_axi_wdata), 64'hDEAD_BEEF);
        chk("wstrb_single", 64'(m_axi_wstrb), 64'hF);
        in_vld[2] = 1'b1; in_dat[2] = 64'd0;
        tick();
        idle_all();
        chk("bvalid_single", 64'(s_axi_bvalid), 64'd1);
        chk("bresp_okay", 64'(s_axi_bresp), 64'd0);
        in_vld[3] = 1'b1; in_dat[3] = {29'd0, 3'd0, 32'h8000_0000};
        tick();
        idle_all();
        chk("araddr_readback", 64'(m_axi_araddr), 64'h8000_0000);
        in_vld[4] = 1'b1; in_dat[4] = {30'd0, 2'b00, 32'hDEAD_BEEF};
        tick();
        idle_all();
        chk("rdata_readback", 64'(s_axi_rdata), 64'hDEAD_BEEF);
        chk("rresp_readback", 64'(s_axi_rresp), 64'd0);
        tick();

        // Back-to-back streaming, 8 AR and 8 R beats
        for (int k = 0; k < 8; k++) begin
            in_vld[3] = 1'b1; in_dat[3] = {29'd0, 3'd0, 32'h8000_0000 + 32'(4 * k)};
            in_vld[4] = 1'b1; in_dat[4] = {30'd0, 2'b00, 32'h1000 + 32'(k)};
            tick();
            chk($sformatf("stream_arvalid%0d", k), 64'(m_axi_arvalid), 64'd1);
            chk($sformatf("stream_araddr%0d", k), 64'(m_axi_araddr), 64'h8000_0000 + 64'(4 * k));
            chk($sformatf("stream_rdata%0d", k), 64'(s_axi_rdata), 64'h1000 + 64'(k));
        end
        idle_all();
        tick();

        // Skid fill: downstream AR stalled, three beats offered
        out_rdy[3] = 1'b0;
        in_vld[3] = 1'b1; in_dat[3] = {29'd0, 3'd1, 32'h8000_0100};
        tick();
        in_dat[3] = {29'd0, 3'd2, 32'h8000_0104};
        tick();
        in_dat[3] = {29'd0, 3'd3, 32'h8000_0108};
        chk("skid_full_arready", 64'(s_axi_arready), 64'd0);
        tick();
        chk("skid_stall_arready", 64'(s_axi_arready), 64'd0);
        chk("skid_stall_araddr", 64'(m_axi_araddr), 64'h8000_0100);
        chk("skid_stall_arprot", 64'(m_axi_arprot), 64'd1);
        out_rdy[3] = 1'b1;
        tick();
        chk("skid_drain_b", 64'(m_axi_araddr), 64'h8000_0104);
        chk("skid_drain_ready", 64'(s_axi_arready), 64'd1);
        tick();
        idle_all();
        chk("skid_drain_c", 64'(m_axi_araddr), 64'h8000_0108);
        tick();
        chk("skid_empty", 64'(m_axi_arvalid), 64'd0);

        // Random valid/ready/payload on all channels
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 5; c++) begin
                in_vld[c]  = ($urandom_range(0, 3) != 0);
                in_dat[c]  = {$urandom, $urandom} & chan_mask(c);
                out_rdy[c] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        idle_all();
        for (int c = 0; c < 5; c++) out_rdy[c] = 1'b1;
        repeat (4) tick();
        chk("drain_awvalid", 64'(m_axi_awvalid), 64'd0);

        // Mid-transfer reset with AW full
        out_rdy[0] = 1'b0;
        in_vld[0] = 1'b1; in_dat[0] = {29'd0, 3'd5, 32'hAAAA_0000};
        tick();
        in_dat[0] = {29'd0, 3'd6, 32'hBBBB_0000};
        tick();
        idle_all();
        chk("aw_full_valid", 64'(m_axi_awvalid), 64'd1);
        chk("aw_full_ready", 64'(s_axi_awready), 64'd0);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("async_rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        repeat (3) tick();
        rstn = 1'b1;
        out_rdy[0] = 1'b1;
        tick();
        chk("post_rst_no_stale", 64'(m_axi_awvalid), 64'd0);
        chk("post_rst_awready", 64'(s_axi_awready), 64'd1);
        in_vld[0] = 1'b1; in_dat[0] = {29'd0, 3'd0, 32'h8000_0004};
        in_vld[1] = 1'b1; in_dat[1] = {28'd0, 4'hF, 32'h1234_5678};
        tick();
        idle_all();
        chk("post_rst_awaddr", 64'(m_axi_awaddr), 64'h8000_0004);
        chk("post_rst_wdata", 64'(m_axi_wdata), 64'h1234_5678);
        in_vld[2] = 1'b1; in_dat[2] = 64'd0;
        tick();
        idle_all();
        chk("post_rst_bvalid", 64'(s_axi_bvalid), 64'd1);
        chk("post_rst_bresp", 64'(s_axi_bresp), 64'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4l_slice.md
Name: axi4l_slice

Overview:
- Full AXI4-Lite register slice inserted directly upstream of axi4l_regs, between the bus master or interconnect and the register front end.
- Registers all five channels (AW, W, B, AR, R) with 2-entry skid buffers. This breaks every combinational valid, ready and payload path while sustaining one beat per cycle per channel.
- Protocol-transparent: it never reorders, drops, duplicates or alters beats.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, width of wdata/rdata; must be 32 or 64. wstrb width is DATA_WIDTH/8.
- AW_REG, 1, 1 = skid buffer on AW; 0 = pure wire passthrough.
- W_REG, 1, same for W.
- B_REG, 1, same for B.
- AR_REG, 1, same for AR.
- R_REG, 1, same for R.

Ports:
- clk  in  1  single clock for both sides.
- rstn  in  1  asynchronous, active-low reset.
- s_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  slave-side AW.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  slave-side W.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  slave-side B.
- s_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  slave-side AR.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  slave-side R.
- m_axi_*  mirror set of the s_axi_* ports above, directions reversed; connects to axi4l_regs s_axi_*.

Behaviour:
- Reset:
  - Asserted asynchronously when rstn falls. Release is synchronous to clk.
  - While rstn=0: all *valid outputs = 0, all *ready outputs = 0, all payload outputs = 0.
  - First rising edge with rstn=1: every input-side ready goes to 1. Valids stay 0 until data is accepted.
  - Reset mid-transfer discards all buffered beats silently. No beat is emitted after reset.
- Each registered channel is one axi4l_skid_buf with three states:
  - EMPTY: out_valid=0, in_ready=1. in_valid moves it to BUSY; payload is loaded into the main register.
  - BUSY: out_valid=1, in_ready=1.
    - in_valid & out_ready: main reloads with the new beat, stay BUSY.
    - in_valid & !out_ready: beat goes to the skid register, go to FULL.
    - !in_valid & out_ready: go to EMPTY.
    - otherwise hold.
  - FULL: out_valid=1, in_ready=0. out_ready moves skid to main, go to BUSY. Otherwise hold.
- Timing:
  - Latency is exactly 1 cycle: a beat accepted at edge N is presented on the output from N+1.
  - Throughput is 1 beat/cycle when downstream ready stays high.
  - in_ready and out_valid are driven directly from flops; no combinational in-to-out path on any signal.
- Payload is stable while out_valid=1 and out_ready=0 (AXI rule). Payload flops are enabled only on load.
- Channels are fully independent. AW and W may be accepted in any order or cycle relative to each other. B and R are forwarded without checking any outstanding count.
- *_REG=0: that channel is assign-only; its ready, valid and payload are combinational wires.
- Simultaneous load and unload in BUSY: the old beat leaves and the new beat enters in the same edge. No bubble, no loss.
- Two beats can be buffered per channel. A third in_valid while FULL is back-pressured (in_ready=0).

Decomposition:
- axi4l_pkg gains:
  - localparams AXI4L_RESP_OKAY=2'b00, AXI4L_RESP_SLVERR=2'b10, AXI4L_RESP_DECERR=2'b11;
  - typedef axi4l_skid_state_t enum {SKID_EMPTY, SKID_BUSY, SKID_FULL}.
- Sub-module axi4l_skid_buf:
  - parameter WIDTH; ports clk, rstn, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
- The top instantiates it five times, once per channel. Payload is concatenated as follows:
  - AW = {prot, addr}
  - W = {strb, data}
  - B = resp
  - AR = {prot, addr}
  - R = {resp, data}

Test Plan:
- Reset release:
  - Hold rstn=0 for 10 cycles -> all valids and readies are 0 throughout.
  - First edge after release -> s_axi_awready, s_axi_wready, s_axi_arready and m_axi_bready, m_axi_rready = 1.
- Single write through slice into axi4l_regs + reg_block:
  - Stimulus: write 0x80000000 <= 0xDEADBEEF, wstrb=4'hF.
  - Required: m_axi_awvalid rises exactly 1 cycle after s-side acceptance; bresp=OKAY.
  - Readback of 0x80000000 returns 0xDEADBEEF.
- Back-to-back streaming: 8 consecutive AR beats (0x80000000..0x8000001C) with rready held 1 -> 8 R beats on consecutive cycles, no bubbles, in order.
- Skid fill:
  - Stimulus: hold m_axi_arready=0, offer 3 AR beats.
  - Required: first two accepted, s_axi_arready=0 on the third.
  - Release arready -> beats emerge in order, payload unchanged while stalled.
- Random back-pressure: 1000 writes and reads with random valid and ready toggling -> scoreboard shows zero lost or duplicated beats. An AXI assertion checker flags no payload change while valid & !ready.
- Mid-transfer reset:
  - Stimulus: assert rstn=0 while the AW channel is FULL.
  - Required: m_axi_awvalid drops to 0 asynchronously, before the next clk edge.
  - After release, no stale beat appears; a new write to 0x80000004 <= 0x12345678 completes normally.
